// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Brief    : Round-robin front end sharing one multi-cycle barrel shifter among
//            eBPF ALU lanes, with eBPF shift-amount masking and ALU32 handling.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int data_width = 64,
    parameter int num_req    = 4,
    parameter int idx_width  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_stb,
    input  logic [num_req-1:0]            req_arith,
    input  logic [num_req-1:0]            req_left,
    input  logic [num_req-1:0]            req_alu32,
    input  logic [num_req*data_width-1:0] req_value,
    input  logic [num_req*data_width-1:0] req_shift,
    output logic [data_width-1:0]         req_out,
    output logic [num_req-1:0]            req_ack,
    output logic                          busy,
    output logic [idx_width-1:0]          grant_id,
    output logic                          sh_stb,
    output logic                          sh_arith,
    output logic                          sh_left,
    output logic [data_width-1:0]         sh_value,
    output logic [data_width-1:0]         sh_shift,
    input  logic [data_width-1:0]         sh_out,
    input  logic                          sh_ack
);

    localparam int c_AMT_W = 6;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_drain_cnt;
    logic [idx_width-1:0]  r_grant_id;
    logic [data_width-1:0] r_value;
    logic [c_AMT_W-1:0]    r_shift;
    logic                  r_arith;
    logic                  r_left;
    logic                  r_alu32;
    logic [data_width-1:0] r_out;
    logic [num_req-1:0]    r_ack;

    logic                  w_grant;
    logic                  w_done;
    logic [idx_width-1:0]  w_win;
    logic [data_width-1:0] w_win_value;
    logic [c_AMT_W-1:0]    w_win_amt;
    logic                  w_win_arith;
    logic                  w_win_left;
    logic                  w_win_alu32;
    logic [data_width-1:0] w_load_value;
    logic [c_AMT_W-1:0]    w_load_shift;
    logic [data_width-1:0] w_result;

    logic [data_width-1:0] w_lane_value [num_req];
    logic [c_AMT_W-1:0]    w_lane_shift [num_req];

    for (genvar gi = 0; gi < num_req; gi++) begin : g_lane
        assign w_lane_value[gi] = req_value[gi*data_width +: data_width];
        assign w_lane_shift[gi] = req_shift[gi*data_width +: c_AMT_W];
    end

    // Shift amounts above bit 5 are masked off by eBPF semantics.
    logic w_unused_shift;
    assign w_unused_shift = ^req_shift;

    // First requester found scanning upward from last+1, wrapping at num_req.
    function automatic logic [idx_width-1:0] rr_pick(input logic [num_req-1:0]   stb,
                                                     input logic [idx_width-1:0] last);
        logic [idx_width-1:0] pick;
        int                   cand;
        pick = last;
        for (int k = num_req; k >= 1; k--) begin
            cand = (int'(last) + k) % num_req;
            if (stb[cand[idx_width-1:0]]) pick = cand[idx_width-1:0];
        end
        return pick;
    endfunction

    always_comb begin
        w_win       = rr_pick(req_stb, r_grant_id);
        w_win_value = w_lane_value[w_win];
        w_win_amt   = w_lane_shift[w_win];
        w_win_arith = req_arith[w_win];
        w_win_left  = req_left[w_win];
        w_win_alu32 = req_alu32[w_win];
        if (w_win_alu32) begin
            w_load_shift = {1'b0, w_win_amt[4:0]};
            if (w_win_arith && !w_win_left)
                w_load_value = {{(data_width-32){w_win_value[31]}}, w_win_value[31:0]};
            else
                w_load_value = {{(data_width-32){1'b0}}, w_win_value[31:0]};
        end else begin
            w_load_shift = w_win_amt;
            w_load_value = w_win_value;
        end
    end

    assign w_result = r_alu32 ? {{(data_width-32){1'b0}}, sh_out[31:0]} : sh_out;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_DRAIN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_done  = 1'b0;
        sh_stb  = 1'b0;
        busy    = 1'b1;
        case (r_state)
            ST_DRAIN: if (r_drain_cnt == 2'd2) w_next = ST_IDLE;
            ST_IDLE: begin
                busy = 1'b0;
                if (|req_stb) begin
                    w_grant = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sh_stb = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: if (sh_ack) begin
                w_done = 1'b1;
                w_next = ST_RESP;
            end
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_DRAIN) r_drain_cnt <= 2'd0;
        else                            r_drain_cnt <= r_drain_cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= idx_width'(num_req - 1);
            r_value    <= '0;
            r_shift    <= '0;
            r_arith    <= 1'b0;
            r_left     <= 1'b0;
            r_alu32    <= 1'b0;
            r_out      <= '0;
            r_ack      <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_grant_id <= w_win;
                r_value    <= w_load_value;
                r_shift    <= w_load_shift;
                r_arith    <= w_win_arith;
                r_left     <= w_win_left;
                r_alu32    <= w_win_alu32;
            end
            if (w_done) begin
                r_out <= w_result;
                r_ack <= {{(num_req-1){1'b0}}, 1'b1} << r_grant_id;
            end
        end
    end

    assign req_out  = r_out;
    assign req_ack  = r_ack;
    assign grant_id = r_grant_id;
    assign sh_arith = r_arith;
    assign sh_left  = r_left;
    assign sh_value = r_value;
    assign sh_shift = {{(data_width-c_AMT_W){1'b0}}, r_shift};

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed self-checking bench for shift_arbiter with a 2-stage
//            behavioural shifter that re-reads sh_value when it acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_stb, req_arith, req_left, req_alu32;
    logic [NR*DW-1:0]   req_value, req_shift;
    logic [DW-1:0]      req_out;
    logic [NR-1:0]      req_ack;
    logic               busy;
    logic [IW-1:0]      grant_id;
    logic               sh_stb, sh_arith, sh_left;
    logic [DW-1:0]      sh_value, sh_shift;
    logic [DW-1:0]      sh_out = '0;
    logic               sh_ack;
    logic               m_s1 = 1'b0;
    logic               m_ack = 1'b0;
    logic               inj_ack = 1'b0;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    assign sh_ack = m_ack | inj_ack;

    shift_arbiter #(.data_width(DW), .num_req(NR), .idx_width(IW)) dut (
        .clk(clk), .rst(rst),
        .req_stb(req_stb), .req_arith(req_arith), .req_left(req_left), .req_alu32(req_alu32),
        .req_value(req_value), .req_shift(req_shift),
        .req_out(req_out), .req_ack(req_ack), .busy(busy), .grant_id(grant_id),
        .sh_stb(sh_stb), .sh_arith(sh_arith), .sh_left(sh_left),
        .sh_value(sh_value), .sh_shift(sh_shift), .sh_out(sh_out), .sh_ack(sh_ack)
    );

    function automatic logic [63:0] ref_shift(input logic [63:0] v, input logic [63:0] s,
                                              input logic a, input logic l);
        logic [5:0] n;
        n = s[5:0];
        if (l)      return v << n;
        else if (a) return $signed(v) >>> n;
        else        return v >> n;
    endfunction

    // Strobe sampled at E1, ack driven for the cycle after E2; result uses sh_value at E2.
    always @(posedge clk) begin
        m_s1  <= (sh_stb === 1'b1);
        m_ack <= m_s1;
        if (m_s1) sh_out <= ref_shift(sh_value, sh_shift, sh_arith, sh_left);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int idx, input logic [63:0] v, input logic [63:0] s,
                         input logic a, input logic l, input logic w32,
                         input logic [63:0] exp_val, input logic [63:0] exp_shift,
                         input logic [63:0] exp_out, input string tag);
        int n;
        logic [NR-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        req_value[idx*DW +: DW] = v;
        req_shift[idx*DW +: DW] = s;
        req_arith[idx] = a;
        req_left[idx]  = l;
        req_alu32[idx] = w32;
        req_stb = onehot;
        n = 0;
        while (sh_stb !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, ":stb"}, sh_stb, 1);
        check({tag, ":grant"}, grant_id, idx);
        check({tag, ":sh_value"}, sh_value, exp_val);
        check({tag, ":sh_shift"}, sh_shift, exp_shift);
        check({tag, ":sh_ctl"}, {sh_arith, sh_left}, {a, l});
        n = 0;
        while (req_ack === '0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, ":latency"}, n, 3);
        check({tag, ":ack"}, req_ack, onehot);
        check({tag, ":out"}, req_out, exp_out);
        req_stb = '0;
        tick();
        check({tag, ":ack_drop"}, req_ack, 0);
        check({tag, ":out_hold"}, req_out, exp_out);
    endtask

    initial begin
        int k, pulses, dbl;
        logic prev_stb;
        logic [NR-1:0] exp_ack;

        rst = 1'b1;
        req_stb = '0; req_arith = '0; req_left = '0; req_alu32 = '0;
        req_value = '0; req_shift = '0;

        // Reset/drain, with lane 0 holding an ALU64 arithmetic-right request.
        req_value[0 +: DW] = 64'h8000_0000_0000_0010;
        req_shift[0 +: DW] = 64'h44;
        req_arith[0] = 1'b1;
        req_stb = 4'b0001;
        tick();
        check("rst:busy", busy, 1);
        check("rst:grant_id", grant_id, NR-1);
        check("rst:req_out", req_out, 0);
        check("rst:req_ack", req_ack, 0);
        check("rst:sh_ctl", {sh_stb, sh_value, sh_shift}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain:busy", busy, 1);
            check("drain:sh_stb", sh_stb, 0);
            tick();
        end
        check("drain:idle", busy, 0);
        tick();
        check("a64:stb", sh_stb, 1);
        check("a64:grant", grant_id, 0);
        check("a64:sh_shift", sh_shift, 4);
        check("a64:sh_value", sh_value, 64'h8000_0000_0000_0010);
        tick();
        check("a64:stb_pulse", sh_stb, 0);
        tick();
        check("a64:no_early_ack", req_ack, 0);
        tick();
        check("a64:ack", req_ack, 4'b0001);
        check("a64:out", req_out, 64'hF800_0000_0000_0001);
        req_stb = '0;
        tick();
        check("a64:ack_drop", req_ack, 0);

        do_op(1, 64'h1234_5678_8000_0000, 64'd35, 1'b1, 1'b0, 1'b1,
              64'hFFFF_FFFF_8000_0000, 64'd3, 64'h0000_0000_F000_0000, "a32_ar");
        do_op(2, 64'hFFFF_FFFF_0000_0001, 64'd31, 1'b0, 1'b1, 1'b1,
              64'h0000_0000_0000_0001, 64'd31, 64'h0000_0000_8000_0000, "a32_l");
        do_op(3, 64'h8000_0000_0000_0001, 64'd65, 1'b0, 1'b1, 1'b0,
              64'h8000_0000_0000_0001, 64'd1, 64'h0000_0000_0000_0002, "a64_l");
        do_op(0, 64'hDEAD_BEEF_8000_0001, 64'd33, 1'b1, 1'b1, 1'b1,
              64'h0000_0000_8000_0001, 64'd1, 64'h0000_0000_0000_0002, "a32_arl");
        do_op(1, 64'hFFFF_FFFF_8000_0000, 64'd4, 1'b0, 1'b0, 1'b1,
              64'h0000_0000_8000_0000, 64'd4, 64'h0000_0000_0800_0000, "a32_lr");

        // Stray shifter ack while idle must not produce a completion.
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        check("stray:req_ack", req_ack, 0);
        check("stray:busy", busy, 0);
        tick();
        check("stray:req_ack2", req_ack, 0);
        check("stray:out_hold", req_out, 64'h0000_0000_0800_0000);

        // Round-robin with all four lanes requesting continuously.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_value[i*DW +: DW] = 64'(i + 1) << 8;
            req_shift[i*DW +: DW] = 64'd4;
        end
        req_arith = '0; req_left = '0; req_alu32 = '0;
        req_stb = 4'b1111;
        pulses = 0;
        dbl = 0;
        prev_stb = 1'b0;
        for (int n = 0; n < 5; n++) begin
            k = 0;
            do begin
                tick();
                k++;
                if (sh_stb === 1'b1) begin
                    pulses++;
                    if (prev_stb) dbl++;
                end
                prev_stb = (sh_stb === 1'b1);
            end while (req_ack === '0 && k < 40);
            exp_ack = '0;
            exp_ack[n % NR] = 1'b1;
            check("rr:ack_order", req_ack, exp_ack);
            check("rr:out", req_out, 64'((n % NR) + 1) << 4);
            if (n > 0) check("rr:spacing", k, 5);
        end
        req_stb = '0;
        check("rr:stb_pulses", pulses, 5);
        check("rr:stb_double", dbl, 0);
        tick();

        // Reset during WAIT: the shifter's ack lands in DRAIN and is dropped.
        req_value[2*DW +: DW] = 64'hF0;
        req_shift[2*DW +: DW] = 64'd4;
        req_stb = 4'b0100;
        k = 0;
        while (sh_stb !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("rstw:stb", sh_stb, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw:busy", busy, 1);
        check("rstw:no_ack", req_ack, 0);
        check("rstw:out_cleared", req_out, 0);
        tick();
        check("rstw:no_ack2", req_ack, 0);
        check("rstw:out_cleared2", req_out, 0);
        do_op(2, 64'hF0, 64'd4, 1'b0, 1'b0, 1'b0, 64'hF0, 64'd4, 64'h0F, "rstw_reserve");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
